temporal_pulse_encoder: RTL and testbench

- Converts binary spike times into pulse-width temporal signals, one wire per channel, aligned to a free-running gamma cycle.
- It is the transmit side of the pulse-width race-logic interface: it produces the aclk-synchronous pulses that exclusive_min and other temporal primitives consume.
- Values are handed over with a valid/ready handshake, double-buffered, and emitted in the next gamma cycle.

---
 rtl/temporal_pkg.sv | 19 +
 rtl/temporal_pulse_ch.sv | 88 ++++++++
 rtl/temporal_pulse_encoder.sv | 82 ++++++++
 tb/tb_temporal_pulse_encoder.sv | 268 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/temporal_pkg.sv
// Shared types and constants for the temporal pulse encoder.
// Optional build macro TEMPORAL_PULSE_ENCODER_EDGE_EN selects edge-transition mode.
package temporal_pkg;

   localparam int GAMMA_CYCLE_WIDTH_DEF = 16;
   localparam int VAL_W_DEF             = $clog2(GAMMA_CYCLE_WIDTH_DEF) + 1;

   typedef logic [VAL_W_DEF-1:0] spike_time_t;

   // Any value >= GAMMA_CYCLE_WIDTH means "no spike"; all ones is the canonical one.
   localparam spike_time_t NULL_VAL = '1;

   typedef enum logic [1:0] {
      IDLE,
      FIRE,
      DONE
   } ch_state_e;

endpackage

// File: rtl/temporal_pulse_ch.sv
// One output channel: spike-time FSM with pulse down-counter and registered output.
// TEMPORAL_PULSE_ENCODER_EDGE_EN keeps the output high from the spike until the gamma wrap.
module temporal_pulse_ch
   import temporal_pkg::*;
#(
   parameter int PULSE_WIDTH = 8,
   parameter int VAL_W       = VAL_W_DEF
) (
   input  logic             aclk,
   input  logic             grst_n,
   input  logic             i_en,
   input  logic             i_wrap,
   input  logic [VAL_W-1:0] i_cnt_next,
   input  logic [VAL_W-1:0] i_v_load,
   output logic             o_q
);

   ch_state_e        r_state;
   logic [VAL_W-1:0] r_v;
   logic             r_q;
`ifndef TEMPORAL_PULSE_ENCODER_EDGE_EN
   localparam logic [VAL_W-1:0] LEFT_INIT = VAL_W'(PULSE_WIDTH - 1);
   logic [VAL_W-1:0] r_left;
`endif

   // Decisions use the counter value of the coming cycle so q lines up with gamma_cnt.
   always_ff @(posedge aclk or negedge grst_n) begin
      if (!grst_n) begin
         r_state <= IDLE;
         r_v     <= '1;
         r_q     <= 1'b0;
`ifndef TEMPORAL_PULSE_ENCODER_EDGE_EN
         r_left  <= '0;
`endif
      end else if (!i_en) begin
         r_q <= 1'b0;
      end else if (i_wrap) begin
         r_v <= i_v_load;
         if (i_v_load == '0) begin
            r_state <= FIRE;
            r_q     <= 1'b1;
`ifndef TEMPORAL_PULSE_ENCODER_EDGE_EN
            r_left  <= LEFT_INIT;
`endif
         end else begin
            r_state <= IDLE;
            r_q     <= 1'b0;
         end
      end else begin
         case (r_state)
            IDLE: begin
               if (i_cnt_next == r_v) begin
                  r_state <= FIRE;
                  r_q     <= 1'b1;
`ifndef TEMPORAL_PULSE_ENCODER_EDGE_EN
                  r_left  <= LEFT_INIT;
`endif
               end else begin
                  r_q <= 1'b0;
               end
            end
            FIRE: begin
`ifndef TEMPORAL_PULSE_ENCODER_EDGE_EN
               if (r_left == '0) begin
                  r_state <= DONE;
                  r_q     <= 1'b0;
               end else begin
                  r_left <= r_left - 1'b1;
                  r_q    <= 1'b1;
               end
`else
               r_q <= 1'b1;
`endif
            end
            DONE: begin
               r_q <= 1'b0;
            end
            default: begin
               r_state <= IDLE;
               r_q     <= 1'b0;
            end
         endcase
      end
   end

   assign o_q = r_q;

endmodule

// File: rtl/temporal_pulse_encoder.sv
// Gamma counter, double-buffered spike-time sets with valid/ready intake, NUM_CH pulse channels.
// Build macro TEMPORAL_PULSE_ENCODER_EDGE_EN: pulses become rising edges held to the gamma wrap.
module temporal_pulse_encoder
   import temporal_pkg::*;
#(
   parameter int NUM_CH            = 4,
   parameter int GAMMA_CYCLE_WIDTH = GAMMA_CYCLE_WIDTH_DEF,
   parameter int PULSE_WIDTH       = 8,
   parameter int VAL_W             = $clog2(GAMMA_CYCLE_WIDTH) + 1
) (
   input  logic                    aclk,
   input  logic                    grst_n,
   input  logic                    en,
   input  logic                    in_valid,
   output logic                    in_ready,
   input  logic [NUM_CH*VAL_W-1:0] in_vals,
   output logic [NUM_CH-1:0]       q,
   output logic [VAL_W-1:0]        gamma_cnt,
   output logic                    gamma_start
);

   localparam logic [VAL_W-1:0] LAST_POS = VAL_W'(GAMMA_CYCLE_WIDTH - 1);

   logic [VAL_W-1:0]        r_cnt;
   logic [NUM_CH*VAL_W-1:0] r_shadow;
   logic                    r_shadow_full;
   logic                    r_gamma_start;

   logic [VAL_W-1:0]        w_cnt_next;
   logic [NUM_CH*VAL_W-1:0] w_load_vals;
   logic                    w_accept;
   logic                    w_wrap;

   assign w_accept   = in_valid && !r_shadow_full;
   assign w_wrap     = en && (r_cnt == LAST_POS);
   assign w_cnt_next = (r_cnt == LAST_POS) ? '0 : r_cnt + 1'b1;

   // A set accepted on the wrap edge skips the shadow and goes live immediately.
   assign w_load_vals = r_shadow_full ? r_shadow : (w_accept ? in_vals : '1);

   always_ff @(posedge aclk or negedge grst_n) begin
      if (!grst_n) begin
         r_cnt         <= '0;
         r_shadow      <= '1;
         r_shadow_full <= 1'b0;
         r_gamma_start <= 1'b0;
      end else begin
         if (en) begin
            r_cnt <= w_cnt_next;
         end
         r_gamma_start <= en && (w_cnt_next == '0);
         if (w_wrap) begin
            r_shadow_full <= 1'b0;
         end else if (w_accept) begin
            r_shadow      <= in_vals;
            r_shadow_full <= 1'b1;
         end
      end
   end

   generate
      for (genvar gi = 0; gi < NUM_CH; gi++) begin : g_ch
         temporal_pulse_ch #(
            .PULSE_WIDTH (PULSE_WIDTH),
            .VAL_W       (VAL_W)
         ) u_ch (
            .aclk       (aclk),
            .grst_n     (grst_n),
            .i_en       (en),
            .i_wrap     (w_wrap),
            .i_cnt_next (w_cnt_next),
            .i_v_load   (w_load_vals[gi*VAL_W +: VAL_W]),
            .o_q        (q[gi])
         );
      end
   endgenerate

   assign in_ready    = !r_shadow_full;
   assign gamma_cnt   = r_cnt;
   assign gamma_start = r_gamma_start;

endmodule

// File: tb/tb_temporal_pulse_encoder.sv
// Self-checking bench: directed scenarios plus random traffic against a gamma-cycle level model.
// Honors TEMPORAL_PULSE_ENCODER_EDGE_EN for the expected pulse shape.
module tb_temporal_pulse_encoder;

   localparam int NUM_CH = 4;
   localparam int G      = 16;
   localparam int PW     = 8;
   localparam int VW     = $clog2(G) + 1;
   localparam int NUL    = 2 * G - 1;

   logic                 aclk = 1'b0;
   logic                 grst_n;
   logic                 en;
   logic                 in_valid;
   logic [NUM_CH*VW-1:0] in_vals;
   logic                 in_ready;
   logic [NUM_CH-1:0]    q;
   logic [VW-1:0]        gamma_cnt;
   logic                 gamma_start;

   always #5 aclk = ~aclk;

   temporal_pulse_encoder #(
      .NUM_CH            (NUM_CH),
      .GAMMA_CYCLE_WIDTH (G),
      .PULSE_WIDTH       (PW),
      .VAL_W             (VW)
   ) dut (
      .aclk        (aclk),
      .grst_n      (grst_n),
      .en          (en),
      .in_valid    (in_valid),
      .in_ready    (in_ready),
      .in_vals     (in_vals),
      .q           (q),
      .gamma_cnt   (gamma_cnt),
      .gamma_start (gamma_start)
   );

   int n_checks = 0;
   int n_errors = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   // Model: which spike-time set is live this gamma cycle, and where in the cycle we are.
   int m_cnt;
   int m_active[NUM_CH];
   int m_shadow[NUM_CH];
   bit m_full;
   bit m_qen;

   always @(posedge aclk or negedge grst_n) begin
      if (!grst_n) begin
         m_cnt  <= 0;
         m_full <= 1'b0;
         m_qen  <= 1'b0;
         for (int i = 0; i < NUM_CH; i++) begin
            m_active[i] <= NUL;
            m_shadow[i] <= NUL;
         end
      end else begin
         m_qen <= en;
         if (en && m_cnt == G - 1) begin
            m_cnt  <= 0;
            m_full <= 1'b0;
            for (int i = 0; i < NUM_CH; i++)
               m_active[i] <= m_full ? m_shadow[i] :
                              (in_valid ? int'(in_vals[i*VW +: VW]) : NUL);
         end else begin
            if (en) m_cnt <= m_cnt + 1;
            if (in_valid && !m_full) begin
               m_full <= 1'b1;
               for (int i = 0; i < NUM_CH; i++)
                  m_shadow[i] <= int'(in_vals[i*VW +: VW]);
            end
         end
      end
   end

   function automatic logic [NUM_CH-1:0] model_q();
      logic [NUM_CH-1:0] r;
      r = '0;
      for (int i = 0; i < NUM_CH; i++) begin
         int v;
         v = m_active[i];
`ifdef TEMPORAL_PULSE_ENCODER_EDGE_EN
         if (m_qen && v < G && v <= m_cnt) r[i] = 1'b1;
`else
         if (m_qen && v < G && v <= m_cnt && m_cnt < v + PW) r[i] = 1'b1;
`endif
      end
      return r;
   endfunction

   always @(negedge aclk) begin
      if (grst_n === 1'b1) begin
         check("q", 32'(q), 32'(model_q()));
         check("gamma_cnt", 32'(gamma_cnt), 32'(m_cnt));
         check("gamma_start", 32'(gamma_start), 32'(m_qen && m_cnt == 0));
         check("in_ready", 32'(in_ready), 32'(!m_full));
      end
   end

   task automatic step();
      @(negedge aclk);
      #1;
   endtask

   function automatic logic [NUM_CH*VW-1:0] pack4(input int c0, input int c1, input int c2, input int c3);
      return {VW'(c3), VW'(c2), VW'(c1), VW'(c0)};
   endfunction

   task automatic offer(input logic [NUM_CH*VW-1:0] vals);
      in_valid = 1'b1;
      in_vals  = vals;
      for (int k = 0; k < 200; k++) begin
         if (in_ready) begin
            step();
            in_valid = 1'b0;
            return;
         end
         step();
      end
      check("offer_timeout", 32'(in_ready), 32'd1);
      in_valid = 1'b0;
   endtask

   task automatic wait_cnt(input int c);
      for (int k = 0; k < 64; k++) begin
         if (int'(gamma_cnt) == c) return;
         step();
      end
      check("wait_cnt_timeout", 32'(gamma_cnt), 32'(c));
   endtask

   logic [NUM_CH-1:0] pat1 [16];
   int                starts;
   bit                acc_prev;

   initial begin
`ifdef TEMPORAL_PULSE_ENCODER_EDGE_EN
      pat1 = '{4'b1000, 4'b1000, 4'b1001, 4'b1001, 4'b1011, 4'b1011, 4'b1011, 4'b1011,
               4'b1011, 4'b1011, 4'b1011, 4'b1011, 4'b1011, 4'b1011, 4'b1011, 4'b1011};
`else
      pat1 = '{4'b1000, 4'b1000, 4'b1001, 4'b1001, 4'b1011, 4'b1011, 4'b1011, 4'b1011,
               4'b0011, 4'b0011, 4'b0010, 4'b0010, 4'b0000, 4'b0000, 4'b0000, 4'b0000};
`endif
      grst_n   = 1'b0;
      en       = 1'b0;
      in_valid = 1'b0;
      in_vals  = '1;
      repeat (3) step();
      check("reset_q", 32'(q), 32'd0);
      check("reset_gamma_cnt", 32'(gamma_cnt), 32'd0);
      check("reset_gamma_start", 32'(gamma_start), 32'd0);
      check("reset_in_ready", 32'(in_ready), 32'd1);

      // Idle run: three gamma cycles, no input.
      grst_n = 1'b1;
      en     = 1'b1;
      starts = 0;
      for (int k = 0; k < 3 * G; k++) begin
         step();
         if (gamma_start) starts++;
         check("idle_q", 32'(q), 32'd0);
      end
      check("idle_start_count", 32'(starts), 32'd3);

      // {2,4,NULL,0} emitted in the following gamma cycle.
      offer(pack4(2, 4, NUL, 0));
      wait_cnt(0);
      for (int c = 0; c < G; c++) begin
         check($sformatf("pat1_cnt%0d", c), 32'(q), 32'(pat1[c]));
         step();
      end
      check("pat1_next_gamma", 32'(q), 32'd0);

      // Late spike truncated at the gamma boundary.
      offer(pack4(12, NUL, NUL, NUL));
      wait_cnt(0);
      wait_cnt(11);
      check("v12_cnt11", 32'(q), 32'd0);
      for (int c = 12; c < G; c++) begin
         step();
         check($sformatf("v12_cnt%0d", c), 32'(q), 32'd1);
      end
      step();
      check("v12_wrap", 32'(q), 32'd0);

      // Backpressure: second set waits for the shadow to drain.
      wait_cnt(3);
      offer(pack4(1, NUL, NUL, NUL));
      in_vals  = pack4(6, NUL, NUL, NUL);
      in_valid = 1'b1;
      step();
      check("bp_ready_low", 32'(in_ready), 32'd0);
      offer(pack4(6, NUL, NUL, NUL));
      wait_cnt(1);
      check("bp_first_set", 32'(q), 32'd1);
      wait_cnt(0);
      step();
      check("bp_second_cnt1", 32'(q), 32'd0);
      wait_cnt(6);
      check("bp_second_cnt6", 32'(q), 32'd1);

      // Freeze mid-pulse, then asynchronous reset at cnt 5.
      offer(pack4(1, NUL, NUL, NUL));
      wait_cnt(0);
      wait_cnt(3);
      check("pre_freeze_q", 32'(q), 32'd1);
      en = 1'b0;
      step();
      check("freeze_q", 32'(q), 32'd0);
      check("freeze_cnt", 32'(gamma_cnt), 32'd3);
      step();
      check("freeze_cnt_hold", 32'(gamma_cnt), 32'd3);
      check("freeze_start", 32'(gamma_start), 32'd0);
      en = 1'b1;
      step();
      check("resume_cnt", 32'(gamma_cnt), 32'd4);
      check("resume_q", 32'(q), 32'd1);
      step();
      grst_n = 1'b0;
      #1;
      check("async_rst_q", 32'(q), 32'd0);
      check("async_rst_cnt", 32'(gamma_cnt), 32'd0);
      check("async_rst_ready", 32'(in_ready), 32'd1);
      step();
      grst_n = 1'b1;
      step();
      check("post_rst_cnt", 32'(gamma_cnt), 32'd1);
      check("post_rst_q", 32'(q), 32'd0);
      repeat (2 * G) step();

      // Random traffic with random enable gaps and occasional resets.
      acc_prev = 1'b0;
      for (int k = 0; k < 3000; k++) begin
         step();
         if (acc_prev) in_valid = 1'b0;
         if ($urandom_range(0, 399) == 0) begin
            grst_n   = 1'b0;
            in_valid = 1'b0;
            step();
            grst_n = 1'b1;
         end
         if (!in_valid && $urandom_range(0, 3) == 0) begin
            in_valid = 1'b1;
            for (int i = 0; i < NUM_CH; i++)
               in_vals[i*VW +: VW] = ($urandom_range(0, 3) == 0) ? VW'(NUL) : VW'($urandom_range(0, G - 1));
         end
         en       = ($urandom_range(0, 7) != 0);
         acc_prev = in_valid && in_ready;
      end
      in_valid = 1'b0;
      step();
      step();

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
